// File: rtl/arena_map_axi.sv
// Arena tile map: 256 x 4-bit tile codes with a registered pixel read port and an
// AXI4-Lite slave for CPU tile writes/reads and bulk fill through a CTRL register.
module arena_map_axi #(
    parameter int         ADDR_WIDTH = 11,
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] INIT_TILE  = 4'h0
) (
    input  logic                  i_pclk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_axi_addr,
    output logic [3:0]            o_axi_data,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WADDR, S_WDATA, S_WRITE, S_BRESP, S_RDATA, S_FILL
    } state_t;

    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'('h400);

    state_t                r_state;
    logic [7:0]            r_fill_idx;
    logic [3:0]            r_fill_val;
    logic                  r_fill_pending;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [7:0]            r_wdata;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [3:0]            r_rdata;
    logic [3:0]            r_mem [256];

    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_ar_hs;
    logic       w_arready;
    logic       w_aw_tile;
    logic       w_aw_ctrl;
    logic       w_ar_tile;
    logic       w_ar_ctrl;
    logic       w_mem_we;
    logic [7:0] w_mem_addr;
    logic [3:0] w_mem_data;
    logic       w_unused;

    // A pending write address or data on the bus always wins over a read.
    assign w_arready = (r_state == S_IDLE) && !s_axi_awvalid && !s_axi_wvalid;
    assign w_aw_hs   = s_axi_awvalid && r_awready;
    assign w_w_hs    = s_axi_wvalid && r_wready;
    assign w_ar_hs   = s_axi_arvalid && w_arready;

    assign w_aw_tile = (r_awaddr[ADDR_WIDTH-1:10] == '0);
    assign w_aw_ctrl = (r_awaddr[ADDR_WIDTH-1:2] == CTRL_ADDR[ADDR_WIDTH-1:2]);
    assign w_ar_tile = (s_axi_araddr[ADDR_WIDTH-1:10] == '0);
    assign w_ar_ctrl = (s_axi_araddr[ADDR_WIDTH-1:2] == CTRL_ADDR[ADDR_WIDTH-1:2]);

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_arready = w_arready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = {{(DATA_WIDTH-4){1'b0}}, r_rdata};

    assign w_unused = ^{r_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[DATA_WIDTH-1:8]};

    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = r_fill_idx;
        w_mem_data = r_fill_val;
        if (r_state == S_INIT || r_state == S_FILL) begin
            w_mem_we = 1'b1;
        end else if (r_state == S_WRITE && w_aw_tile) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_awaddr[9:2];
            w_mem_data = r_wdata[3:0];
        end
    end

    // The sweep rewrites every entry after reset, so the array itself needs no reset.
    always_ff @(posedge i_pclk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) o_axi_data <= '0;
        else          o_axi_data <= r_mem[i_axi_addr];
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_INIT;
            r_fill_idx     <= '0;
            r_fill_val     <= INIT_TILE;
            r_fill_pending <= 1'b0;
            r_awaddr       <= '0;
            r_wdata        <= '0;
            r_awready      <= 1'b0;
            r_wready       <= 1'b0;
            r_bvalid       <= 1'b0;
            r_bresp        <= RESP_OKAY;
            r_rvalid       <= 1'b0;
            r_rresp        <= RESP_OKAY;
            r_rdata        <= '0;
        end else begin
            if (w_aw_hs) r_awaddr <= s_axi_awaddr;
            if (w_w_hs)  r_wdata  <= s_axi_wdata[7:0];
            case (r_state)
                S_INIT, S_FILL: begin
                    r_fill_idx <= r_fill_idx + 8'd1;
                    if (r_fill_idx == 8'hFF) begin
                        r_state   <= S_IDLE;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_state   <= S_WRITE;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                    end else if (w_aw_hs) begin
                        r_state   <= S_WDATA;
                        r_awready <= 1'b0;
                    end else if (w_w_hs) begin
                        r_state  <= S_WADDR;
                        r_wready <= 1'b0;
                    end else if (w_ar_hs) begin
                        r_state   <= S_RDATA;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_ar_tile ? r_mem[s_axi_araddr[9:2]] : 4'h0;
                        r_rresp   <= (w_ar_tile || w_ar_ctrl) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                S_WADDR: begin
                    if (w_aw_hs) begin
                        r_state   <= S_WRITE;
                        r_awready <= 1'b0;
                    end
                end
                S_WDATA: begin
                    if (w_w_hs) begin
                        r_state  <= S_WRITE;
                        r_wready <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_state  <= S_BRESP;
                    r_bvalid <= 1'b1;
                    r_bresp  <= (w_aw_tile || w_aw_ctrl) ? RESP_OKAY : RESP_SLVERR;
                    if (w_aw_ctrl && r_wdata[0]) begin
                        r_fill_val     <= r_wdata[7:4];
                        r_fill_pending <= 1'b1;
                    end
                end
                S_BRESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_bresp  <= RESP_OKAY;
                        if (r_fill_pending) begin
                            r_state        <= S_FILL;
                            r_fill_idx     <= '0;
                            r_fill_pending <= 1'b0;
                        end else begin
                            r_state   <= S_IDLE;
                            r_awready <= 1'b1;
                            r_wready  <= 1'b1;
                        end
                    end
                end
                S_RDATA: begin
                    if (s_axi_rready) begin
                        r_state   <= S_IDLE;
                        r_rvalid  <= 1'b0;
                        r_rresp   <= RESP_OKAY;
                        r_rdata   <= '0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_arena_map_axi.sv
// Bench for arena_map_axi: directed AXI4-Lite transactions push expected B/R responses
// into queues; a negedge monitor pops and compares them when the DUT presents a beat.
`timescale 1ns/1ps
module tb_arena_map_axi;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic          clk = 1'b0;
    logic          rstN;
    logic [7:0]    pixAddr;
    logic [3:0]    pixData;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    logic [1:0]  bQueue [$];
    logic [33:0] rQueue [$];
    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    arena_map_axi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_TILE(4'h0)) dut (
        .i_pclk(clk), .i_rst_n(rstN), .i_axi_addr(pixAddr), .o_axi_data(pixData),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        $display("[TB] FAIL %s: timed out waiting for handshake", name);
    endtask

    // Monitor: compare each B/R beat the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (rstN && bvalid && bready) begin
            if (bQueue.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL bresp_unexpected: got 0x%0h, expected no response", bresp);
            end else begin
                checkOutput("bresp", 32'(bresp), 32'(bQueue.pop_front()));
            end
        end
        if (rstN && rvalid && rready) begin
            if (rQueue.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL rdata_unexpected: got 0x%0h, expected no response", rdata);
            end else begin
                logic [33:0] exp;
                exp = rQueue.pop_front();
                checkOutput("rdata", rdata, exp[31:0]);
                checkOutput("rresp", 32'(rresp), 32'(exp[33:32]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sigSel(input int which);
        case (which)
            0:       return awready;
            1:       return wready;
            2:       return arready;
            3:       return bvalid;
            default: return rvalid;
        endcase
    endfunction

    task automatic waitHigh(input int which, input string name);
        int n = 0;
        while (!sigSel(which) && n < 600) begin
            tick(1);
            n++;
        end
        if (!sigSel(which)) timeoutFail(name);
    endtask

    // mode 0: AW and W together; mode 1: W first; mode 2: AW first; gap in cycles.
    task automatic axiWriteIssue(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [1:0] resp, input int mode, input int gap,
                                 input bit expectResp);
        if (expectResp) bQueue.push_back(resp);
        if (mode == 0) begin
            awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
            waitHigh(0, "aw_ready");
            tick(1);
            awvalid = 1'b0; wvalid = 1'b0;
        end else if (mode == 1) begin
            wdata = d; wvalid = 1'b1;
            waitHigh(1, "w_ready");
            tick(1);
            wvalid = 1'b0;
            tick(gap - 1);
            awaddr = a; awvalid = 1'b1;
            waitHigh(0, "aw_ready");
            tick(1);
            awvalid = 1'b0;
        end else begin
            awaddr = a; awvalid = 1'b1;
            waitHigh(0, "aw_ready");
            tick(1);
            awvalid = 1'b0;
            tick(gap - 1);
            wdata = d; wvalid = 1'b1;
            waitHigh(1, "w_ready");
            tick(1);
            wvalid = 1'b0;
        end
    endtask

    task automatic axiWriteFinish();
        waitHigh(3, "b_valid");
        tick(1);
    endtask

    task automatic axiRead(input logic [AW-1:0] a, input logic [31:0] expData, input logic [1:0] resp);
        rQueue.push_back({resp, expData});
        araddr = a; arvalid = 1'b1;
        waitHigh(2, "ar_ready");
        tick(1);
        arvalid = 1'b0;
        checkOutput("rvalid_latency", 32'(rvalid), 32'd1);
        waitHigh(4, "r_valid");
        tick(1);
    endtask

    task automatic pixelCheck(input string name, input logic [7:0] a, input logic [3:0] expected);
        pixAddr = a;
        tick(1);
        checkOutput(name, 32'(pixData), 32'(expected));
    endtask

    task automatic sweepReadyLow(input string name);
        int highSeen = 0;
        for (int i = 0; i < 256; i++) begin
            if (awready || wready || arready) highSeen++;
            tick(1);
        end
        checkOutput(name, highSeen, 32'd0);
        checkOutput({name, "_done"}, 32'(awready), 32'd1);
    endtask

    task automatic applyStimulus();
        int heldCycles;
        logic [1:0] respOr;

        rstN = 1'b0; pixAddr = '0; awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
        tick(3);
        checkOutput("rst_awready", 32'(awready), 32'd0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_arready", 32'(arready), 32'd0);
        checkOutput("rst_pixel", 32'(pixData), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        sweepReadyLow("init_ready");
        pixelCheck("init_pixel_37", 8'h37, 4'h0);

        $display("[TB] same-cycle AW/W write");
        awaddr = 11'h0DC; wdata = 32'h5; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        checkOutput("ar_blocked_by_aw", 32'(arready), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        axiWriteIssue(11'h0DC, 32'h5, OKAY, 0, 0, 1'b1);
        checkOutput("bvalid_cycle1", 32'(bvalid), 32'd0);
        tick(1);
        checkOutput("bvalid_cycle2", 32'(bvalid), 32'd1);
        axiWriteFinish();
        pixelCheck("pixel_37_after_write", 8'h37, 4'h5);

        $display("[TB] W before AW, bready held low");
        bready = 1'b0;
        axiWriteIssue(11'h004, 32'hA, OKAY, 1, 3, 1'b1);
        waitHigh(3, "b_valid");
        heldCycles = 0;
        respOr = 2'b00;
        for (int i = 0; i < 5; i++) begin
            if (bvalid) heldCycles++;
            respOr = respOr | bresp;
            tick(1);
        end
        checkOutput("bvalid_held", heldCycles, 32'd5);
        checkOutput("bresp_stable", 32'(respOr), 32'd0);
        bready = 1'b1;
        axiWriteFinish();
        pixelCheck("pixel_01", 8'h01, 4'hA);

        $display("[TB] AW before W");
        axiWriteIssue(11'h008, 32'hFFFF_FF06, OKAY, 2, 2, 1'b1);
        axiWriteFinish();
        axiRead(11'h008, 32'h6, OKAY);

        $display("[TB] error and control decode");
        axiWriteIssue(11'h500, 32'h7, SLVERR, 0, 0, 1'b1);
        axiWriteFinish();
        pixelCheck("pixel_40_untouched", 8'h40, 4'h0);
        axiRead(11'h600, 32'h0, SLVERR);
        axiRead(11'h7FC, 32'h0, SLVERR);
        axiRead(11'h0DC, 32'h5, OKAY);
        axiRead(11'h006, 32'hA, OKAY);
        axiRead(11'h400, 32'h0, OKAY);
        axiWriteIssue(11'h400, 32'hF0, OKAY, 0, 0, 1'b1);
        axiWriteFinish();
        checkOutput("ctrl_noop_idle", 32'(arready), 32'd1);
        pixelCheck("pixel_37_after_noop", 8'h37, 4'h5);

        $display("[TB] bulk fill");
        axiWriteIssue(11'h401, 32'h31, OKAY, 0, 0, 1'b1);
        axiWriteFinish();
        sweepReadyLow("fill_ready");
        for (int i = 0; i < 256; i++) begin
            pixAddr = 8'(i);
            axiRead(AW'(i * 4), 32'h3, OKAY);
            checkOutput($sformatf("fill_pixel_%0d", i), 32'(pixData), 32'h3);
        end

        $display("[TB] reset during BRESP");
        bready = 1'b0;
        axiWriteIssue(11'h0DC, 32'h9, OKAY, 0, 0, 1'b0);
        waitHigh(3, "b_valid");
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_bvalid", 32'(bvalid), 32'd0);
        checkOutput("midreset_awready", 32'(awready), 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        rstN = 1'b1;
        sweepReadyLow("reinit_ready");
        pixelCheck("reinit_pixel_37", 8'h37, 4'h0);
        axiRead(11'h0DC, 32'h0, OKAY);

        tick(2);
        checkOutput("bqueue_drained", bQueue.size(), 32'd0);
        checkOutput("rqueue_drained", rQueue.size(), 32'd0);
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
